// File: rtl/nand_job_pkg.sv
// ============================================================================
// Module   : nand_job_pkg
// Brief    : Shared types and round-robin helper for nand_job_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nand_job_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Widest requester field the helper supports (NREQ <= 8).
  localparam int NREQ_MAX = 8;

  // First set bit of valid at or after ptr, wrapping at n-1 -> 0.
  // Scanned farthest-first so the nearest candidate is written last.
  function automatic int rr_pick(input logic [NREQ_MAX-1:0] valid,
                                 input int ptr, input int n);
    int idx;
    rr_pick = ptr;
    for (int k = NREQ_MAX - 1; k >= 0; k--) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && valid[idx[2:0]]) rr_pick = idx;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/nand_pipe.sv
// ============================================================================
// Module   : nand_pipe
// Brief    : LATENCY-stage registered bitwise NAND with a valid bit alongside.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nand_pipe #(
  parameter int W       = 8,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [LATENCY-1:0] r_valid;
  logic [W-1:0]       r_data [LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < LATENCY; s++) r_data[s] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= ~(i_a & i_b);
      for (int s = 1; s < LATENCY; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/nand_job_arbiter.sv
// ============================================================================
// Module   : nand_job_arbiter
// Brief    : Round-robin scheduler sharing one pipelined NAND unit among NREQ
//            requesters; one job in flight, results tagged with requester ID.
//            Optional macro NAND_JOB_ARBITER_STATS_EN adds per-requester
//            saturating grant counters on grant_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nand_job_arbiter
  import nand_job_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*W-1:0]     req_a,
  input  logic [NREQ*W-1:0]     req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [W-1:0]          resp_data,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] resp_id,
  input  logic                  resp_ready,
  output logic                  busy
`ifdef NAND_JOB_ARBITER_STATS_EN
  ,
  output logic [NREQ*8-1:0]     grant_cnt
`endif
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]      r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic            r_resp_valid;
  logic [W-1:0]    r_resp_data;
  logic [ID_W-1:0] r_resp_id;

  logic            w_grant_en;
  logic            w_accept;
  logic [ID_W-1:0] w_win;
  logic [ID_W-1:0] w_ptr_next;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic            w_pipe_valid;
  logic [W-1:0]    w_pipe_data;

  assign w_grant_en = ena && (r_state == S_IDLE) && (|req_valid);
  assign w_win      = ID_W'(rr_pick(NREQ_MAX'(req_valid), int'(r_ptr), NREQ));
  assign w_ptr_next = (w_win == ID_W'(NREQ - 1)) ? '0 : w_win + ID_W'(1);
  assign w_accept   = |(req_valid & req_ready);

  always_comb begin
    req_ready = '0;
    w_a       = '0;
    w_b       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_a = req_a[i*W +: W];
        w_b = req_b[i*W +: W];
        if (w_grant_en) req_ready[i] = 1'b1;
      end
    end
  end

  // The pipe captures the winner's operands on the accept edge itself.
  nand_pipe #(
    .W       (W),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_accept),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_valid (w_pipe_valid),
    .o_data  (w_pipe_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_id    <= w_win;
            r_ptr   <= w_ptr_next;
          end
        end
        S_BUSY: begin
          if (w_pipe_valid) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_pipe_data;
            r_resp_id    <= r_id;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign busy       = (r_state != S_IDLE);

`ifdef NAND_JOB_ARBITER_STATS_EN
  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_stats
      logic [7:0] r_cnt;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (req_valid[g] && req_ready[g] && (r_cnt != 8'hFF)) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
      assign grant_cnt[g*8 +: 8] = r_cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_nand_job_arbiter.sv
// ============================================================================
// Module   : tb_nand_job_arbiter
// Brief    : Directed self-checking bench for nand_job_arbiter (NREQ=4, W=8,
//            LATENCY=2); stats checks build when NAND_JOB_ARBITER_STATS_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nand_job_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic        resp_ready;
  logic        busy;
`ifdef NAND_JOB_ARBITER_STATS_EN
  logic [31:0] grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  nand_job_arbiter #(
    .NREQ    (4),
    .W       (8),
    .LATENCY (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy)
`ifdef NAND_JOB_ARBITER_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         exp_id [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_d  [5] = '{8'hF0, 8'hCC, 8'hAA, 8'hFF, 8'hF0};

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    req_valid  = 4'b0000;
    req_a      = 32'h0;
    req_b      = 32'h0;
    resp_ready = 1'b0;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", 32'(resp_data), 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step();

    // Single job from requester 1: ~(F0 & CC) = 3F
    req_a     = 32'h0000_F000;
    req_b     = 32'h0000_CC00;
    req_valid = 4'b0010;
    #1;
    chk("single_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_rv_lat0", 32'(resp_valid), 32'h0);
    step();
    chk("single_rv_lat1", 32'(resp_valid), 32'h0);
    step();
    chk("single_rv_lat2", 32'(resp_valid), 32'h1);
    chk("single_data", 32'(resp_data), 32'h3F);
    chk("single_id", 32'(resp_id), 32'h1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("single_rv_drop", 32'(resp_valid), 32'h0);
    chk("single_data_hold", 32'(resp_data), 32'h3F);
    chk("single_idle", 32'(busy), 32'h0);

    // Round-robin with all four requesting after a reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req_a      = 32'hFFFF_FFFF;
    req_b      = 32'h0055_330F;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1) << exp_id[k]);
      step();
      chk($sformatf("rr_noready_%0d", k), 32'(req_ready), 32'h0);
      step();
      step();
      chk($sformatf("rr_rv_%0d", k), 32'(resp_valid), 32'h1);
      chk($sformatf("rr_id_%0d", k), 32'(resp_id), 32'(exp_id[k]));
      chk($sformatf("rr_data_%0d", k), 32'(resp_data), 32'(exp_d[k]));
      step();
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    step();

    // Backpressure: rr_ptr is 1, so requester 2 wins
    req_valid = 4'b0100;
    #1;
    chk("bp_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b1111;
    step();
    step();
    chk("bp_rv", 32'(resp_valid), 32'h1);
    chk("bp_id", 32'(resp_id), 32'h2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp_hold_rv_%0d", k), 32'(resp_valid), 32'h1);
      chk($sformatf("bp_hold_data_%0d", k), 32'(resp_data), 32'hAA);
      chk($sformatf("bp_hold_ready_%0d", k), 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    step();
    chk("bp_release_rv", 32'(resp_valid), 32'h0);
    chk("bp_next_grant", 32'(req_ready), 32'h8);
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    step();

    // ena gating; rr_ptr stays 3 since the grant above was not taken
    ena       = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("ena0_ready", 32'(req_ready), 32'h0);
    step();
    chk("ena0_ready_cyc", 32'(req_ready), 32'h0);
    chk("ena0_busy", 32'(busy), 32'h0);
    ena = 1'b1;
    #1;
    chk("ena1_ready", 32'(req_ready), 32'h4);
    step();
    ena       = 1'b0;
    req_valid = 4'b0000;
    step();
    step();
    chk("ena_drop_rv", 32'(resp_valid), 32'h1);
    chk("ena_drop_id", 32'(resp_id), 32'h2);
    chk("ena_drop_data", 32'(resp_data), 32'hAA);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    ena        = 1'b1;
    chk("ena_done_rv", 32'(resp_valid), 32'h0);

    // Reset while BUSY: rr_ptr 3 -> requester 0 wins first
    req_valid = 4'b0001;
    #1;
    chk("mid_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_rv", 32'(resp_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    step();
    step();
    chk("mid_rst_no_stale", 32'(resp_valid), 32'h0);
    req_valid = 4'b1001;
    #1;
    chk("mid_rst_ptr0", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    step();

`ifdef NAND_JOB_ARBITER_STATS_EN
    chk("stats_zero", grant_cnt, 32'h0);
    req_valid  = 4'b1000;
    resp_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      step();
      step();
      step();
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    step();
    step();
    chk("stats_sat", grant_cnt, 32'hFF00_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
